irrigation_valve_scheduler: RTL and testbench

//  Arbitrates the sprinkler (ASP) and drip (GOT) irrigation valves between two

---
 rtl/irrigation_valve_scheduler.sv | 117 +++++++++++
 tb/tb_irrigation_valve_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_valve_scheduler.sv
// Sprinkler/drip valve arbiter: min on-time, dead-time gap, low-tank lockout.
// Define WATCHDOG_EN to enable the MAX_ON watchdog and sticky timeout flag.
module irrigation_valve_scheduler #(
    parameter int MIN_ON    = 8,
    parameter int DEAD_TIME = 4,
    parameter int MAX_ON    = 64,
    parameter int CNT_W     = 8
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       req_asp,
    input  logic       req_got,
    input  logic       tank_low,
    output logic       asp,
    output logic       got,
    output logic [1:0] cout,
    output logic       alarm,
    output logic       timeout
);

    typedef enum logic [2:0] {
        IDLE,
        ASP_ON,
        GOT_ON,
        GAP,
        LOCK
    } state_t;

`ifdef WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_TIME - 1);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_ON - 1);

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic             last_got;
    logic             own;
    logic             other;
    logic             wd_fire;

    always_comb begin
        nxt     = state;
        wd_fire = 1'b0;
        own     = (state == ASP_ON) ? req_asp : req_got;
        other   = (state == ASP_ON) ? req_got : req_asp;
        case (state)
            IDLE: begin
                if (tank_low)
                    nxt = LOCK;
                else if (req_asp && req_got)
                    nxt = last_got ? ASP_ON : GOT_ON;
                else if (req_asp)
                    nxt = ASP_ON;
                else if (req_got)
                    nxt = GOT_ON;
            end
            ASP_ON, GOT_ON: begin
                if (tank_low)
                    nxt = LOCK;
                else if (cnt >= MIN_LAST && (!own || other))
                    nxt = GAP;
                else if (WD_EN && cnt == MAX_LAST) begin
                    nxt     = GAP;
                    wd_fire = 1'b1;
                end
            end
            GAP: begin
                if (tank_low)
                    nxt = LOCK;
                else if (cnt == DEAD_LAST)
                    nxt = IDLE;
            end
            LOCK: begin
                if (!tank_low)
                    nxt = GAP;
            end
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change with it.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            last_got <= 1'b1;
            timeout  <= 1'b0;
            asp      <= 1'b0;
            got      <= 1'b0;
            cout     <= 2'b00;
            alarm    <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != state)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + CNT_W'(1);
            if (nxt == ASP_ON && state != ASP_ON)
                last_got <= 1'b0;
            if (nxt == GOT_ON && state != GOT_ON)
                last_got <= 1'b1;
            timeout <= timeout | wd_fire;
            asp     <= (nxt == ASP_ON);
            got     <= (nxt == GOT_ON);
            alarm   <= (nxt == LOCK);
            cout    <= {nxt == GOT_ON || nxt == LOCK,
                        nxt == ASP_ON || nxt == LOCK};
        end
    end

endmodule

// File: tb/tb_irrigation_valve_scheduler.sv
// Randomized bench for irrigation_valve_scheduler against a cycle model.
// Honours WATCHDOG_EN the same way as the design.
module tb_irrigation_valve_scheduler;

    localparam int MIN_ON    = 8;
    localparam int DEAD_TIME = 4;
    localparam int MAX_ON    = 64;

    logic       CLK      = 1'b0;
    logic       reset    = 1'b1;
    logic       req_asp  = 1'b0;
    logic       req_got  = 1'b0;
    logic       tank_low = 1'b0;
    logic       asp;
    logic       got;
    logic [1:0] cout;
    logic       alarm;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    irrigation_valve_scheduler #(
        .MIN_ON    (MIN_ON),
        .DEAD_TIME (DEAD_TIME),
        .MAX_ON    (MAX_ON),
        .CNT_W     (8)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .req_asp  (req_asp),
        .req_got  (req_got),
        .tank_low (tank_low),
        .asp      (asp),
        .got      (got),
        .cout     (cout),
        .alarm    (alarm),
        .timeout  (timeout)
    );

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: which valve is open (0 none, 1 ASP, 2 GOT), how long it
    // has been open, lockout, and how many dead-time cycles have elapsed.
    int m_valve = 0;
    int m_open  = 0;
    bit m_lock  = 0;
    bit m_gap   = 0;
    int m_gapn  = 0;
    int m_last  = 2;
    bit m_to    = 0;

    task automatic model_reset();
        m_valve = 0;
        m_open  = 0;
        m_lock  = 0;
        m_gap   = 0;
        m_gapn  = 0;
        m_last  = 2;
        m_to    = 0;
    endtask

    task automatic start_gap();
        m_valve = 0;
        m_gap   = 1;
        m_gapn  = 1;
    endtask

    task automatic model_step(bit ra, bit rg, bit tl);
        bit own;
        bit oth;
        own = (m_valve == 1) ? ra : rg;
        oth = (m_valve == 1) ? rg : ra;
        if (tl) begin
            m_lock  = 1;
            m_valve = 0;
            m_gap   = 0;
        end else if (m_lock) begin
            m_lock = 0;
            start_gap();
        end else if (m_valve != 0) begin
            if (m_open >= MIN_ON && (!own || oth))
                start_gap();
`ifdef WATCHDOG_EN
            else if (m_open == MAX_ON) begin
                start_gap();
                m_to = 1;
            end
`endif
            else
                m_open++;
        end else if (m_gap) begin
            if (m_gapn == DEAD_TIME)
                m_gap = 0;
            else
                m_gapn++;
        end else if (ra || rg) begin
            if (ra && rg)
                m_valve = (m_last == 2) ? 1 : 2;
            else
                m_valve = ra ? 1 : 2;
            m_last = m_valve;
            m_open = 1;
        end
    endtask

    always @(posedge CLK) begin
        bit ra, rg, tl, rs;
        ra = req_asp;
        rg = req_got;
        tl = tank_low;
        rs = reset;
        if (rs)
            model_reset();
        else
            model_step(ra, rg, tl);
        #1;
        check("asp", asp, m_valve == 1);
        check("got", got, m_valve == 2);
        check("cout", cout, m_lock ? 3 : m_valve);
        check("alarm", alarm, m_lock);
        check("timeout", timeout, m_to);
    end

    initial begin
        int n;
        int k;

        repeat (2) @(negedge CLK);
        check("rst_asp", asp, 0);
        check("rst_got", got, 0);
        check("rst_cout", cout, 0);
        check("rst_alarm", alarm, 0);
        check("rst_timeout", timeout, 0);
        reset = 1'b0;

        // One-cycle ASP pulse still gets the full minimum on-time.
        @(negedge CLK);
        req_asp = 1'b1;
        @(negedge CLK);
        check("pulse_open", asp, 1);
        req_asp = 1'b0;
        n = asp;
        repeat (19) begin
            @(negedge CLK);
            n += asp;
        end
        check("pulse_len", n, 8);

        // Tank goes low on the third ASP cycle.
        req_asp = 1'b1;
        repeat (3) @(negedge CLK);
        check("tank_pre_asp", asp, 1);
        tank_low = 1'b1;
        @(negedge CLK);
        check("lock_asp", asp, 0);
        check("lock_cout", cout, 3);
        check("lock_alarm", alarm, 1);
        tank_low = 1'b0;
        @(negedge CLK);
        check("unlock_cout", cout, 0);
        check("unlock_alarm", alarm, 0);
        k = 0;
        while (!asp && k < 20) begin
            @(negedge CLK);
            k++;
        end
        check("regrant", asp, 1);
        req_asp = 1'b0;
        repeat (20) @(negedge CLK);

        // Both held; reset during GOT_ON restarts with ASP.
        req_asp = 1'b1;
        req_got = 1'b1;
        k = 0;
        while (!got && k < 60) begin
            @(negedge CLK);
            k++;
        end
        check("got_reached", got, 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_got", got, 0);
        check("midrst_cout", cout, 0);
        check("midrst_alarm", alarm, 0);
        check("midrst_timeout", timeout, 0);
        @(negedge CLK);
        reset = 1'b0;
        k = 0;
        while (!(asp || got) && k < 20) begin
            @(negedge CLK);
            k++;
        end
        check("rr_first_asp", {asp, got}, 2'b10);
        n = 0;
        while (asp && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("rr_asp_len", n, 8);
        k = 0;
        while (!(asp || got) && k < 20) begin
            @(negedge CLK);
            k++;
        end
        check("rr_then_got", {asp, got}, 2'b01);
        req_asp = 1'b0;
        req_got = 1'b0;
        repeat (20) @(negedge CLK);

        // A single held request against the watchdog.
        reset = 1'b1;
        @(negedge CLK);
        reset   = 1'b0;
        req_asp = 1'b1;
        k = 0;
        while (!asp && k < 10) begin
            @(negedge CLK);
            k++;
        end
        n = 0;
        while (asp && n < 100) begin
            @(negedge CLK);
            n++;
        end
`ifdef WATCHDOG_EN
        check("wd_len", n, 64);
        check("wd_timeout", timeout, 1);
        k = 0;
        while (!asp && k < 20) begin
            @(negedge CLK);
            k++;
        end
        check("wd_regrant", asp, 1);
        check("wd_sticky", timeout, 1);
`else
        check("hold_len", n, 100);
        check("hold_timeout", timeout, 0);
`endif
        req_asp = 1'b0;
        repeat (20) @(negedge CLK);

        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 7) == 0)
                req_asp = ~req_asp;
            if ($urandom_range(0, 7) == 0)
                req_got = ~req_got;
            if (tank_low)
                tank_low = ($urandom_range(0, 3) != 0);
            else
                tank_low = ($urandom_range(0, 79) == 0);
            reset = ($urandom_range(0, 499) == 0);
        end
        reset = 1'b0;
        repeat (2) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
